// File: rtl/vend_pkg.sv
// vend_pkg: types and constants shared by the change dispenser.
//   coin_t       - ejector coin code (none/nickel/dime/quarter)
//   VAL_*        - coin values in cents
//   FAULT_*      - fault_code values
//   disp_state_t - dispenser FSM states
//   coin_value() - coin code to value in cents
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_t;

   localparam logic [7:0] VAL_NICKEL  = 8'd5;
   localparam logic [7:0] VAL_DIME    = 8'd10;
   localparam logic [7:0] VAL_QUARTER = 8'd25;

   localparam logic [1:0] FAULT_OK      = 2'b00;
   localparam logic [1:0] FAULT_AMOUNT  = 2'b01;
   localparam logic [1:0] FAULT_STOCK   = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SELECT,
      ST_REQ,
      ST_FINISH
   } disp_state_t;

   function automatic logic [7:0] coin_value(input coin_t coin);
      case (coin)
         COIN_NICKEL:  coin_value = VAL_NICKEL;
         COIN_DIME:    coin_value = VAL_DIME;
         COIN_QUARTER: coin_value = VAL_QUARTER;
         default:      coin_value = 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_select.sv
// coin_select: combinational greedy coin pick.
//   remaining          - cents still owed
//   stock_q/d/n        - coins on hand
//   coin_type          - largest coin that fits and is in stock
//   valid              - a coin was found
module coin_select
   import vend_pkg::*;
#(
   parameter int STOCK_W = 4
) (
   input  logic [7:0]         remaining,
   input  logic [STOCK_W-1:0] stock_q,
   input  logic [STOCK_W-1:0] stock_d,
   input  logic [STOCK_W-1:0] stock_n,
   output coin_t              coin_type,
   output logic               valid
);

   always_comb begin
      coin_type = COIN_NONE;
      valid     = 1'b0;
      if (remaining >= VAL_QUARTER && stock_q != '0) begin
         coin_type = COIN_QUARTER;
         valid     = 1'b1;
      end else if (remaining >= VAL_DIME && stock_d != '0) begin
         coin_type = COIN_DIME;
         valid     = 1'b1;
      end else if (remaining >= VAL_NICKEL && stock_n != '0) begin
         coin_type = COIN_NICKEL;
         valid     = 1'b1;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out `amount` cents with quarters, dimes and nickels.
//   clk, reset_n        - clock, async active-low reset
//   start, amount       - request to dispense amount (ignored while busy)
//   refill              - set all stocks to full (IDLE only)
//   coin_req, coin_type - eject request to the coin ejector
//   coin_ack            - ejector confirms the drop
//   busy, done          - transaction active / one-cycle end pulse
//   fault_code          - 00 ok, 01 bad amount, 10 out of stock, 11 ack timeout
//   remaining           - cents still owed
//   stock_q/d/n         - coins on hand
//
// state  | meaning
// IDLE   | waiting for start; refill accepted here
// CHECK  | validate amount, detect completion
// SELECT | greedy coin pick
// REQ    | coin_req held until coin_ack or timeout
// FINISH | done pulse, back to IDLE
module change_dispenser
   import vend_pkg::*;
#(
   parameter int STOCK_W     = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [7:0]         amount,
   input  logic               refill,
   input  logic               coin_ack,
   output logic               coin_req,
   output logic [1:0]         coin_type,
   output logic               busy,
   output logic               done,
   output logic [1:0]         fault_code,
   output logic [7:0]         remaining,
   output logic [STOCK_W-1:0] stock_q,
   output logic [STOCK_W-1:0] stock_d,
   output logic [STOCK_W-1:0] stock_n
);

   localparam int                 WAIT_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(TIMEOUT_CYC);
   localparam logic [STOCK_W-1:0] STOCK_FULL = '1;

   disp_state_t        state, state_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
   logic               coin_req_nxt, busy_nxt, done_nxt;
   logic [1:0]         coin_type_nxt, fault_nxt;
   logic [7:0]         remaining_nxt;
   logic [STOCK_W-1:0] stock_q_nxt, stock_d_nxt, stock_n_nxt;
   coin_t              sel_coin;
   logic               sel_valid;

   coin_select #(.STOCK_W(STOCK_W)) u_coin_select (
      .remaining (remaining),
      .stock_q   (stock_q),
      .stock_d   (stock_d),
      .stock_n   (stock_n),
      .coin_type (sel_coin),
      .valid     (sel_valid)
   );

   always_comb begin
      state_nxt     = state;
      wait_nxt      = wait_cnt;
      coin_req_nxt  = coin_req;
      coin_type_nxt = coin_type;
      fault_nxt     = fault_code;
      remaining_nxt = remaining;
      stock_q_nxt   = stock_q;
      stock_d_nxt   = stock_d;
      stock_n_nxt   = stock_n;

      case (state)
         ST_IDLE: begin
            if (refill) begin
               stock_q_nxt = STOCK_FULL;
               stock_d_nxt = STOCK_FULL;
               stock_n_nxt = STOCK_FULL;
            end
            if (start) begin
               remaining_nxt = amount;
               fault_nxt     = FAULT_OK;
               state_nxt     = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // after the first coin remaining stays a multiple of 5, so this
            // only ever fires on the amount as latched
            if ((remaining % 8'd5) != 8'd0) begin
               fault_nxt = FAULT_AMOUNT;
               state_nxt = ST_FINISH;
            end else if (remaining == 8'd0) begin
               state_nxt = ST_FINISH;
            end else begin
               state_nxt = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (sel_valid) begin
               coin_type_nxt = sel_coin;
               coin_req_nxt  = 1'b1;
               wait_nxt      = WAIT_LOAD;
               state_nxt     = ST_REQ;
            end else begin
               fault_nxt = FAULT_STOCK;
               state_nxt = ST_FINISH;
            end
         end
         ST_REQ: begin
            if (coin_ack) begin
               remaining_nxt = remaining - coin_value(coin_t'(coin_type));
               case (coin_t'(coin_type))
                  COIN_QUARTER: stock_q_nxt = stock_q - STOCK_W'(1);
                  COIN_DIME:    stock_d_nxt = stock_d - STOCK_W'(1);
                  COIN_NICKEL:  stock_n_nxt = stock_n - STOCK_W'(1);
                  default:      ;
               endcase
               coin_req_nxt  = 1'b0;
               coin_type_nxt = COIN_NONE;
               wait_nxt      = '0;
               state_nxt     = ST_CHECK;
            end else if (wait_cnt == WAIT_W'(1)) begin
               // terminal count: TIMEOUT_CYC cycles spent in REQ
               fault_nxt     = FAULT_TIMEOUT;
               coin_req_nxt  = 1'b0;
               coin_type_nxt = COIN_NONE;
               wait_nxt      = '0;
               state_nxt     = ST_FINISH;
            end else begin
               wait_nxt = wait_cnt - WAIT_W'(1);
            end
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_nxt == ST_FINISH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         coin_req   <= 1'b0;
         coin_type  <= COIN_NONE;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault_code <= FAULT_OK;
         remaining  <= 8'd0;
         stock_q    <= STOCK_FULL;
         stock_d    <= STOCK_FULL;
         stock_n    <= STOCK_FULL;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_nxt;
         coin_req   <= coin_req_nxt;
         coin_type  <= coin_type_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         fault_code <= fault_nxt;
         remaining  <= remaining_nxt;
         stock_q    <= stock_q_nxt;
         stock_d    <= stock_d_nxt;
         stock_n    <= stock_n_nxt;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random transactions against a greedy
// change-making reference model kept in plain arithmetic.
module tb_change_dispenser;

   localparam int STOCK_W     = 4;
   localparam int TIMEOUT_CYC = 255;
   localparam int FULL        = 15;

   logic               clk;
   logic               reset_n;
   logic               start;
   logic [7:0]         amount;
   logic               refill;
   logic               coin_ack;
   logic               coin_req;
   logic [1:0]         coin_type;
   logic               busy;
   logic               done;
   logic [1:0]         fault_code;
   logic [7:0]         remaining;
   logic [STOCK_W-1:0] stock_q;
   logic [STOCK_W-1:0] stock_d;
   logic [STOCK_W-1:0] stock_n;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int ms_q, ms_d, ms_n;
   int exp_coins[$];
   int exp_fault;
   int exp_rem;

   change_dispenser #(.STOCK_W(STOCK_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .amount     (amount),
      .refill     (refill),
      .coin_ack   (coin_ack),
      .coin_req   (coin_req),
      .coin_type  (coin_type),
      .busy       (busy),
      .done       (done),
      .fault_code (fault_code),
      .remaining  (remaining),
      .stock_q    (stock_q),
      .stock_d    (stock_d),
      .stock_n    (stock_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_stocks(input string tag);
      check({tag, "_stock_q"}, stock_q, ms_q);
      check({tag, "_stock_d"}, stock_d, ms_d);
      check({tag, "_stock_n"}, stock_n, ms_n);
   endtask

   task automatic model_full();
      ms_q = FULL; ms_d = FULL; ms_n = FULL;
   endtask

   // greedy change making: quarter, dime, nickel while value fits and coins remain
   task automatic plan(input int amt);
      int rem;
      rem = amt;
      exp_coins.delete();
      exp_fault = 0;
      if (amt % 5 != 0) exp_fault = 1;
      else begin
         while (rem > 0) begin
            if (rem >= 25 && ms_q > 0) begin
               exp_coins.push_back(3); rem -= 25; ms_q--;
            end else if (rem >= 10 && ms_d > 0) begin
               exp_coins.push_back(2); rem -= 10; ms_d--;
            end else if (rem >= 5 && ms_n > 0) begin
               exp_coins.push_back(1); rem -= 5; ms_n--;
            end else begin
               exp_fault = 2;
               break;
            end
         end
      end
      exp_rem = rem;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_coin_req"}, coin_req, 0);
      check({tag, "_coin_type"}, coin_type, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_fault"}, fault_code, 0);
      check({tag, "_remaining"}, remaining, 0);
      check_stocks(tag);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      model_full();
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_txn(input int amt, input bit with_refill, input int dly_min,
                          input int dly_max, input bit hold_ack);
      int cyc, req_age, ack_at, n_acked, req_cycles, first_req, done_cyc, exp_n;
      int sq, sd, sn;
      @(negedge clk);
      start    = 1'b1;
      amount   = amt[7:0];
      refill   = with_refill;
      coin_ack = 1'b0;
      if (with_refill) model_full();
      sq = ms_q; sd = ms_d; sn = ms_n;
      plan(amt);
      exp_n = exp_coins.size();
      if (hold_ack && exp_coins.size() > 0) begin
         exp_fault = 3;
         exp_rem   = amt;
         ms_q = sq; ms_d = sd; ms_n = sn;
         exp_n = 0;
      end

      cyc = 0; req_age = 0; ack_at = 0; n_acked = 0;
      req_cycles = 0; first_req = -1; done_cyc = -1;
      while (done_cyc < 0 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         start    = 1'b0;
         refill   = 1'b0;
         coin_ack = 1'b0;
         if (cyc == 1) check("busy_after_start", busy, 1);
         if (done) done_cyc = cyc;
         else begin
            refill = ($urandom_range(0, 3) == 0);
            if (coin_req) begin
               req_cycles++;
               if (req_age == 0) begin
                  if (first_req < 0) first_req = cyc;
                  check("coin_type", coin_type,
                        (n_acked < exp_coins.size()) ? exp_coins[n_acked] : 0);
                  ack_at = $urandom_range(dly_max, dly_min);
               end
               if (!hold_ack && req_age == ack_at) begin
                  coin_ack = 1'b1;
                  n_acked++;
               end
               req_age++;
            end else begin
               req_age  = 0;
               coin_ack = $urandom_range(0, 1);
               if (cyc == 1) begin
                  start  = 1'b1;
                  amount = ~amount;
               end
            end
         end
      end

      check("done_seen", done_cyc >= 0, 1);
      check("fault_code", fault_code, exp_fault);
      check("remaining", remaining, exp_rem);
      check_stocks("txn");
      check("coins_acked", n_acked, exp_n);
      check("coin_req_at_done", coin_req, 0);
      check("busy_at_done", busy, 1);
      if (exp_coins.size() > 0) check("req_latency", first_req, 3);
      else check("no_coin_req", req_cycles, 0);
      if (hold_ack && exp_coins.size() > 0) check("timeout_cycles", req_cycles, TIMEOUT_CYC);
      if (amt == 0 || amt % 5 != 0) check("done_latency", done_cyc, 2);

      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_not_busy", busy, 0);
      check("fault_held", fault_code, exp_fault);
   endtask

   initial begin
      int a, n, seen;
      bit rf;
      reset_n  = 1'b1;
      start    = 1'b0;
      amount   = 8'd0;
      refill   = 1'b0;
      coin_ack = 1'b0;
      model_full();
      #2;
      apply_reset();

      // 40 cents, ack two cycles after each request
      run_txn(40, 1'b0, 2, 2, 1'b0);
      run_txn(0, 1'b0, 2, 2, 1'b0);
      run_txn(37, 1'b0, 2, 2, 1'b0);
      check("bad_amount_rem", remaining, 37);

      // quarter exhaustion, then dimes and a nickel
      apply_reset();
      run_txn(250, 1'b0, 0, 3, 1'b0);
      run_txn(125, 1'b0, 0, 3, 1'b0);
      check("quarters_gone", stock_q, 0);
      run_txn(25, 1'b0, 0, 3, 1'b0);
      check("dimes_end", stock_d, 13);
      check("nickels_end", stock_n, 14);

      // ack timeout, then refill in IDLE
      run_txn(25, 1'b0, 0, 0, 1'b1);
      @(negedge clk);
      refill = 1'b1;
      model_full();
      @(negedge clk);
      refill = 1'b0;
      check_stocks("refill");

      // reset while coin_req is high
      apply_reset();
      run_txn(40, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      start  = 1'b1;
      amount = 8'd40;
      @(negedge clk);
      start = 1'b0;
      seen  = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         if (coin_req) seen = 1;
         else @(negedge clk);
      end
      check("mid_reset_req_seen", seen, 1);
      #2;
      reset_n = 1'b0;
      model_full();
      #1;
      check_reset_values("mid_reset");
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 2) reset_n = 1'b1;
         if (done) seen = 1;
      end
      check("mid_reset_no_done", seen, 0);
      run_txn(10, 1'b0, 0, 2, 1'b0);

      // random transactions with idle-time refills and stray acks
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) != 0) a = 5 * $urandom_range(0, 51);
         else a = $urandom_range(0, 255);
         rf = ($urandom_range(0, 4) == 0);
         run_txn(a, rf, 0, 4, 1'b0);
         n = $urandom_range(0, 2);
         for (int g = 0; g < n; g++) begin
            refill   = ($urandom_range(0, 3) == 0);
            coin_ack = $urandom_range(0, 1);
            if (refill) model_full();
            @(negedge clk);
            refill   = 1'b0;
            coin_ack = 1'b0;
         end
         check_stocks("idle");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
